// File: rtl/alarm_timebase.sv
// alarm_timebase: time-of-day / weekday keeper with a programmable alarm.
// A prescaler produces one tick per simulated minute. Each tick advances
// hh:mm:dow. A small ring FSM (IDLE / RINGING / SNOOZED) turns an alarm
// match into a clean registered request level for the downstream wake-up FSM.
module alarm_timebase #(
    parameter int CLK_PER_MIN  = 3000,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_MIN = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_time,
    input  logic [4:0] time_hour,
    input  logic [5:0] time_min,
    input  logic [2:0] time_dow,
    input  logic       set_alarm,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_en,
    input  logic       snooze,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [2:0] dow,
    output logic       tick_min,
    output logic       alarme,
    output logic       dia_util
);

    localparam int              PW          = (CLK_PER_MIN > 1) ? $clog2(CLK_PER_MIN) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(CLK_PER_MIN - 1);
    localparam logic [5:0]      SNOOZE_LAST = 6'(SNOOZE_MIN - 1);
    localparam logic [5:0]      RING_LAST   = 6'(RING_MAX_MIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RINGING,
        ST_SNOOZED
    } state_t;

    logic [PW-1:0] presc;
    logic          presc_end;
    logic          load_time;
    logic          load_alarm;
    logic          advance;
    logic          match;

    logic [4:0]    next_hour;
    logic [5:0]    next_minute;
    logic [2:0]    next_dow;

    logic [4:0]    al_hour;
    logic [5:0]    al_minute;

    state_t        state, state_next;
    logic [5:0]    ring_cnt, ring_cnt_next;
    logic [5:0]    snz_cnt, snz_cnt_next;

    // Loads with out-of-range fields are dropped entirely; a valid time load
    // wins over a coinciding prescaler terminal count.
    assign presc_end  = (presc == PRESC_LAST);
    assign load_time  = set_time && (time_hour <= 5'd23) && (time_min <= 6'd59) && (time_dow <= 3'd6);
    assign load_alarm = set_alarm && (alarm_hour <= 5'd23) && (alarm_min <= 6'd59);
    assign advance    = presc_end && !load_time;

    // Alarm is compared against the time about to appear, so alarme rises on the same edge.
    assign match    = advance && alarm_en && (next_hour == al_hour) && (next_minute == al_minute);
    assign dia_util = (dow >= 3'd1) && (dow <= 3'd5);

    // Successor of the current time with minute/hour/weekday carries.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        next_minute = minute + 6'd1;
        next_hour   = hour;
        next_dow    = dow;
        if (minute == 6'd59) begin
            next_minute = 6'd0;
            next_hour   = hour + 5'd1;
            if (hour == 5'd23) begin
                next_hour = 5'd0;
                next_dow  = (dow == 3'd6) ? 3'd0 : dow + 3'd1;
            end
        end
    end

    // Prescaler, time-of-day registers and the minute tick pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc    <= '0;
            hour     <= 5'd0;
            minute   <= 6'd0;
            dow      <= 3'd0;
            tick_min <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            tick_min <= 1'b0;
            if (load_time) begin
                presc  <= '0;
                hour   <= time_hour;
                minute <= time_min;
                dow    <= time_dow;
            end else if (presc_end) begin
                presc    <= '0;
                hour     <= next_hour;
                minute   <= next_minute;
                dow      <= next_dow;
                tick_min <= 1'b1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Stored alarm time; ring state is not touched by reprogramming.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the stored alarm is a plain register pair, so it is reset like any other state (back to 00:00).
            al_hour   <= 5'd0;
            al_minute <= 6'd0;
        end else if (load_alarm) begin
            al_hour   <= alarm_hour;
            al_minute <= alarm_min;
        end
    end

    // Ring FSM next-state: alarm_en low beats snooze, snooze beats tick-driven moves.
    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;
        if (!alarm_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match) begin
                        state_next    = ST_RINGING;
                        ring_cnt_next = 6'd0;
                    end
                end
                ST_RINGING: begin
                    if (snooze) begin
                        state_next   = ST_SNOOZED;
                        snz_cnt_next = 6'd0;
                    end else if (advance) begin
                        if (ring_cnt == RING_LAST) begin
                            state_next = ST_IDLE;
                        end else begin
                            ring_cnt_next = ring_cnt + 6'd1;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (advance) begin
                        if (snz_cnt == SNOOZE_LAST) begin
                            state_next    = ST_RINGING;
                            ring_cnt_next = 6'd0;
                        end else begin
                            snz_cnt_next = snz_cnt + 6'd1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Ring FSM registers; alarme is registered from the next state so it never glitches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ring_cnt <= 6'd0;
            snz_cnt  <= 6'd0;
            alarme   <= 1'b0;
        end else begin
            state    <= state_next;
            ring_cnt <= ring_cnt_next;
            snz_cnt  <= snz_cnt_next;
            alarme   <= (state_next == ST_RINGING);
        end
    end

endmodule

// File: tb/tb_alarm_timebase.sv
// tb_alarm_timebase: scoreboard bench for alarm_timebase with short minutes.
// Expected outputs are queued as stimulus is applied and compared when the
// DUT reaches the corresponding point (load edge, tick, snooze edge).
module tb_alarm_timebase;

    localparam int CPM  = 4;
    localparam int SNZ  = 2;
    localparam int RMAX = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       set_time, set_alarm, alarm_en, snooze;
    logic [4:0] time_hour, alarm_hour;
    logic [5:0] time_min, alarm_min;
    logic [2:0] time_dow;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [2:0] dow;
    logic       tick_min, alarme, dia_util;

    typedef struct {
        string tag;
        int    hour;
        int    minute;
        int    dow;
        int    alarme;
        int    tick;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;

    always #5 clock = ~clock;

    alarm_timebase #(
        .CLK_PER_MIN (CPM),
        .SNOOZE_MIN  (SNZ),
        .RING_MAX_MIN(RMAX)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .set_time  (set_time),
        .time_hour (time_hour),
        .time_min  (time_min),
        .time_dow  (time_dow),
        .set_alarm (set_alarm),
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .alarm_en  (alarm_en),
        .snooze    (snooze),
        .hour      (hour),
        .minute    (minute),
        .dow       (dow),
        .tick_min  (tick_min),
        .alarme    (alarme),
        .dia_util  (dia_util)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int h, input int m, input int d,
                              input int a, input int t);
        exp_t e;
        e.tag = tag; e.hour = h; e.minute = m; e.dow = d; e.alarme = a; e.tick = t;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        int   util;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e    = sb.pop_front();
        util = (e.dow >= 1 && e.dow <= 5) ? 1 : 0;
        check({e.tag, ".hour"},    32'(hour),     32'(e.hour));
        check({e.tag, ".minute"},  32'(minute),   32'(e.minute));
        check({e.tag, ".dow"},     32'(dow),      32'(e.dow));
        check({e.tag, ".alarme"},  32'(alarme),   32'(e.alarme));
        check({e.tag, ".dia_util"},32'(dia_util), 32'(util));
        check({e.tag, ".tick"},    32'(tick_min), 32'(e.tick));
    endtask

    // Advance negedge by negedge until tick_min is seen, with a cycle budget.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (tick_min !== 1'b1 && cycles < 4 * CPM);
        if (tick_min !== 1'b1) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input bit do_time, input int h, input int m, input int d,
                        input bit do_alarm, input int ah, input int am);
        set_time   = do_time;
        time_hour  = 5'(h);
        time_min   = 6'(m);
        time_dow   = 3'(d);
        set_alarm  = do_alarm;
        alarm_hour = 5'(ah);
        alarm_min  = 6'(am);
        @(negedge clock);
        set_time  = 1'b0;
        set_alarm = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        @(negedge clock);
        snooze = 1'b0;
    endtask

    typedef struct { int h; int m; int d; } bad_t;
    bad_t bad_loads[3] = '{'{24, 0, 0}, '{5, 60, 0}, '{5, 0, 7}};

    initial begin
        reset = 1'b0; set_time = 1'b0; set_alarm = 1'b0; alarm_en = 1'b0; snooze = 1'b0;
        time_hour = '0; time_min = '0; time_dow = '0; alarm_hour = '0; alarm_min = '0;
        #12;
        expect_out("reset", 0, 0, 0, 0, 0);
        compare_out();
        @(negedge clock);
        reset = 1'b1;

        // 1. calendar rollover
        expect_out("t1_load", 23, 59, 6, 0, 0);
        load(1, 23, 59, 6, 0, 0, 0);
        compare_out();
        expect_out("t1_wrap", 0, 0, 0, 0, 1);
        wait_tick(cyc);
        compare_out();
        check("t1_tick_latency", 32'(cyc), 32'(CPM));
        expect_out("t1_day", 0, 0, 1, 0, 1);
        for (int i = 0; i < 1440; i++) wait_tick(cyc);
        compare_out();

        // 2. match and ring timeout
        alarm_en = 1'b1;
        expect_out("t2_load", 6, 29, 1, 0, 0);
        load(1, 6, 29, 1, 1, 6, 30);
        compare_out();
        expect_out("t2_ring", 6, 30, 1, 1, 1);
        expect_out("t2_ring1", 6, 31, 1, 1, 1);
        expect_out("t2_ring2", 6, 32, 1, 1, 1);
        expect_out("t2_stop", 6, 33, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            wait_tick(cyc);
            compare_out();
        end

        // 3. snooze twice, then timeout
        load(1, 6, 29, 1, 0, 0, 0);
        expect_out("t3_ring", 6, 30, 1, 1, 1);
        wait_tick(cyc);
        compare_out();
        for (int r = 0; r < 2; r++) begin
            expect_out("t3_snz", 6, 30 + 2 * r, 1, 0, 0);
            pulse_snooze();
            compare_out();
            expect_out("t3_wait", 6, 31 + 2 * r, 1, 0, 1);
            expect_out("t3_rering", 6, 32 + 2 * r, 1, 1, 1);
            wait_tick(cyc);
            compare_out();
            wait_tick(cyc);
            compare_out();
        end
        expect_out("t3_r1", 6, 35, 1, 1, 1);
        expect_out("t3_r2", 6, 36, 1, 1, 1);
        expect_out("t3_end", 6, 37, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(cyc);
            compare_out();
        end

        // 4. direct load onto the alarm time never rings; invalid loads ignored
        expect_out("t4_direct", 6, 30, 1, 0, 0);
        load(1, 6, 30, 1, 0, 0, 0);
        compare_out();
        expect_out("t4_next", 6, 31, 1, 0, 1);
        wait_tick(cyc);
        compare_out();
        foreach (bad_loads[i]) begin
            expect_out("t4_invalid", 6, 31, 1, 0, 0);
            load(1, bad_loads[i].h, bad_loads[i].m, bad_loads[i].d, 1, 24, 0);
            compare_out();
        end
        // prescaler is at its terminal count here: the valid load must suppress the tick
        expect_out("t4_load_vs_tick", 10, 0, 2, 0, 0);
        load(1, 10, 0, 2, 1, 10, 1);
        compare_out();

        // 5. snooze coinciding with a tick, then alarm_en dropped while snoozed
        expect_out("t5_ring", 10, 1, 2, 1, 1);
        wait_tick(cyc);
        compare_out();
        check("t5_tick_latency", 32'(cyc), 32'(CPM));
        repeat (CPM - 1) @(negedge clock);
        expect_out("t5_snz_on_tick", 10, 2, 2, 0, 1);
        pulse_snooze();
        compare_out();
        expect_out("t5_snz_cnt0", 10, 3, 2, 0, 1);
        expect_out("t5_rering", 10, 4, 2, 1, 1);
        wait_tick(cyc);
        compare_out();
        wait_tick(cyc);
        compare_out();
        pulse_snooze();
        alarm_en = 1'b0;
        expect_out("t5_dis1", 10, 5, 2, 0, 1);
        expect_out("t5_dis2", 10, 6, 2, 0, 1);
        expect_out("t5_dis3", 10, 7, 2, 0, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(cyc);
            compare_out();
        end

        // 6. asynchronous reset mid-ring
        alarm_en = 1'b1;
        load(1, 10, 59, 2, 1, 11, 0);
        expect_out("t6_ring", 11, 0, 2, 1, 1);
        wait_tick(cyc);
        compare_out();
        #2 reset = 1'b0;
        #1;
        expect_out("t6_async", 0, 0, 0, 0, 0);
        compare_out();
        @(negedge clock);
        reset = 1'b1;
        expect_out("t6_restart", 0, 1, 0, 0, 1);
        wait_tick(cyc);
        compare_out();
        check("t6_tick_latency", 32'(cyc), 32'(CPM));
        // stored alarm must now be 00:00
        load(1, 23, 59, 3, 0, 0, 0);
        expect_out("t6_alarm_cleared", 0, 0, 4, 1, 1);
        wait_tick(cyc);
        compare_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
